// File: rtl/mem_pkg.sv
// Shared constants, types and state encoding for the memory copy engine slice.
// Pure declarations: no latency, no backpressure.
// Memory geometry is 32 x 8; the copy FSM states live here so bench and RTL agree.
package mem_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } copy_state_e;
endpackage

// File: rtl/mem_if.sv
// Single-port 32x8 memory bus: read/write strobes, address, write data, read data.
// Read data is returned the cycle after the read strobe; writes land at the strobe cycle's closing edge.
// No backpressure: the memory accepts every strobe.
interface mem_if;
    import mem_pkg::*;

    logic  read;
    logic  write;
    addr_t addr;
    data_t data_in;
    data_t data_out;

    modport master (
        output read,
        output write,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  read,
        input  write,
        input  addr,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/mem_copy_top.sv
// Thin wrapper binding the copy engine's memory-side ports to the master modport of mem_if.
// Latency: none added; all timing comes from the engine.
// No backpressure: the memory behind the interface accepts every strobe.
module mem_copy_top
    import mem_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  addr_t           src_addr,
    input  addr_t           dst_addr,
    input  logic [ADDR_W:0] len,
    output logic            busy,
    output logic            done,
    output data_t           csum,
    mem_if.master           mem
);
    mem_copy_engine #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_engine (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .csum      (csum),
        .mem_read  (mem.read),
        .mem_write (mem.write),
        .mem_addr  (mem.addr),
        .mem_wdata (mem.data_in),
        .mem_rdata (mem.data_out)
    );
endmodule

// File: rtl/mem_copy_engine.sv
// Block copy master: reads len bytes from src, writes them ascending to dst, keeps an XOR checksum.
// Latency: 3 cycles per byte (RD, CAP, WR); done pulses 1+3*len cycles after start is accepted.
// No backpressure: read data is expected the cycle after mem_read; start is ignored unless IDLE.
module mem_copy_engine #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] csum,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import mem_pkg::*;

    copy_state_e       state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] idx_nxt;
    logic              more;

    assign idx_nxt = idx + ADDR_W'(1);
    // Compared one bit wider so a 32-byte copy stops after index 31 instead of wrapping.
    assign more    = ({1'b0, idx} + (ADDR_W+1)'(1)) < len_q;

    // mem_wdata doubles as the data register: it is loaded in CAP and presented in WR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            idx       <= '0;
            len_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            csum      <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        len_q <= len;
                        idx   <= '0;
                        csum  <= '0;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= RD;
                            busy     <= 1'b1;
                            mem_read <= 1'b1;
                            mem_addr <= src_addr;
                        end
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    state     <= WR;
                    csum      <= csum ^ mem_rdata;
                    mem_wdata <= mem_rdata;
                    mem_write <= 1'b1;
                    mem_addr  <= dst_q + idx;
                end
                WR: begin
                    if (more) begin
                        state    <= RD;
                        idx      <= idx_nxt;
                        mem_read <= 1'b1;
                        mem_addr <= src_q + idx_nxt;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: directed table, multi-cycle corner sequences,
// and randomized copies checked against a byte-by-byte reference copy of the memory.
`timescale 1ns/1ps
module tb_mem_copy_engine;
    import mem_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    addr_t           src_addr;
    addr_t           dst_addr;
    logic [ADDR_W:0] len;
    logic            busy;
    logic            done;
    data_t           csum;
    logic            busy_w;
    logic            done_w;
    data_t           csum_w;

    always #5 clk = ~clk;

    mem_if mif ();
    mem_if mif_w ();

    mem_copy_engine #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .csum      (csum),
        .mem_read  (mif.read),
        .mem_write (mif.write),
        .mem_addr  (mif.addr),
        .mem_wdata (mif.data_in),
        .mem_rdata (mif.data_out)
    );

    // Wrapper instance shadows the engine; its bus must track the engine's bus exactly.
    mem_copy_top wrap (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy_w),
        .done     (done_w),
        .csum     (csum_w),
        .mem      (mif_w.master)
    );
    assign mif_w.data_out = mif.data_out;

    // Memory slave with a bench-side preload/clear port.
    data_t mem [DEPTH];
    logic  pl_clr;
    logic  pl_we;
    addr_t pl_addr;
    data_t pl_dat;

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (pl_we) begin
            mem[pl_addr] <= pl_dat;
        end else if (mif.write) begin
            mem[mif.addr] <= mif.data_in;
        end
        if (mif.read) mif.data_out <= mem[mif.addr];
    end

    int n_rd = 0, n_wr = 0, n_done = 0, n_ovl = 0, n_wrap_diff = 0;
    always @(negedge clk) begin
        if (mif.read)  n_rd++;
        if (mif.write) n_wr++;
        if (done)      n_done++;
        if (mif.read && mif.write) n_ovl++;
        if ({mif_w.read, mif_w.write, mif_w.addr, mif_w.data_in, busy_w, done_w, csum_w} !==
            {mif.read, mif.write, mif.addr, mif.data_in, busy, done, csum}) n_wrap_diff++;
    end

    int checks = 0, failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_mem();
        pl_clr = 1'b1;
        @(negedge clk);
        pl_clr = 1'b0;
    endtask

    task automatic preload(input int a, input int d);
        pl_we   = 1'b1;
        pl_addr = addr_t'(a);
        pl_dat  = data_t'(d);
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    // Issues start, optionally re-pulses start with other operands at cycle poke_at,
    // returns the cycle (1 = first cycle after the accepting edge) in which done was seen.
    task automatic run_copy(input int s, input int d, input int l, input int poke_at,
                            output int lat, output int busy_first);
        start    = 1'b1;
        src_addr = addr_t'(s);
        dst_addr = addr_t'(d);
        len      = (ADDR_W+1)'(l);
        @(negedge clk);
        start      = 1'b0;
        lat        = -1;
        busy_first = int'(busy);
        for (int k = 1; k <= 200 && lat < 0; k++) begin
            if (done === 1'b1) begin
                lat = k;
            end else begin
                start = (k == poke_at);
                if (k == poke_at) begin
                    src_addr = addr_t'(20);
                    dst_addr = addr_t'(24);
                    len      = (ADDR_W+1)'(2);
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        int src;
        int dst;
        int len;
        int pre_a [4];
        int pre_d [4];
        int chk_a [4];
        int chk_d [4];
        int lat;
        int csum;
    } vec_t;

    vec_t  vecs [4];
    data_t model [DEPTH];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int lat, b1, rd0, wr0, dn0, bad, s, d, l, exp_cs;
        data_t byte_v;

        vecs[0] = '{0, 16, 4, '{0, 1, 2, 3}, '{'h11, 'h22, 'h33, 'h44},
                    '{16, 17, 18, 19}, '{'h11, 'h22, 'h33, 'h44}, 13, 'h44};
        vecs[1] = '{5, 9, 0, '{5, 6, 7, 8}, '{'h5A, 'h5B, 'h5C, 'h5D},
                    '{9, 10, 11, 5}, '{0, 0, 0, 'h5A}, 1, 0};
        vecs[2] = '{30, 2, 4, '{30, 31, 0, 1}, '{'hA0, 'hA1, 'hA2, 'hA3},
                    '{2, 3, 4, 5}, '{'hA0, 'hA1, 'hA2, 'hA3}, 13, 0};
        vecs[3] = '{0, 1, 3, '{0, 1, 2, 3}, '{1, 2, 3, 4},
                    '{0, 1, 2, 3}, '{1, 1, 1, 1}, 10, 1};

        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        pl_clr = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_dat = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_csum",  int'(csum), 0);
        check("rst_read",  int'(mif.read), 0);
        check("rst_write", int'(mif.write), 0);
        check("rst_addr",  int'(mif.addr), 0);
        check("rst_wdata", int'(mif.data_in), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            clear_mem();
            for (int j = 0; j < 4; j++) preload(vecs[v].pre_a[j], vecs[v].pre_d[j]);
            rd0 = n_rd; wr0 = n_wr; dn0 = n_done;
            run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, 0, lat, b1);
            check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("v%0d_busy_first", v), b1, (vecs[v].len != 0) ? 1 : 0);
            @(negedge clk);
            check($sformatf("v%0d_busy_after", v), int'(busy), 0);
            check($sformatf("v%0d_done_1cycle", v), int'(done), 0);
            check($sformatf("v%0d_csum", v), int'(csum), vecs[v].csum);
            @(negedge clk);
            check($sformatf("v%0d_reads", v), n_rd - rd0, vecs[v].len);
            check($sformatf("v%0d_writes", v), n_wr - wr0, vecs[v].len);
            check($sformatf("v%0d_done_pulses", v), n_done - dn0, 1);
            for (int j = 0; j < 4; j++)
                check($sformatf("v%0d_mem[%0d]", v, vecs[v].chk_a[j]),
                      int'(mem[vecs[v].chk_a[j]]), vecs[v].chk_d[j]);
        end

        // Reset mid-copy: reset lands on the edge that would open byte 2's write.
        clear_mem();
        for (int a = 0; a < 8; a++) preload(a, 'h10 + a);
        dn0 = n_done;
        start = 1'b1; src_addr = '0; dst_addr = addr_t'(16); len = (ADDR_W+1)'(8);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_busy",  int'(busy), 0);
        check("rstmid_read",  int'(mif.read), 0);
        check("rstmid_write", int'(mif.write), 0);
        check("rstmid_csum",  int'(csum), 0);
        repeat (3) @(negedge clk);
        check("rstmid_no_done", n_done - dn0, 0);
        check("rstmid_mem16", int'(mem[16]), 'h10);
        check("rstmid_mem17", int'(mem[17]), 'h11);
        check("rstmid_mem18", int'(mem[18]), 0);
        run_copy(0, 20, 3, 0, lat, b1);
        check("rstmid_recopy_latency", lat, 10);
        @(negedge clk);
        check("rstmid_recopy_csum", int'(csum), 'h10 ^ 'h11 ^ 'h12);
        check("rstmid_recopy_mem22", int'(mem[22]), 'h12);

        // Start re-pulsed mid-copy with different operands must be ignored.
        clear_mem();
        for (int a = 0; a < 4; a++) preload(a, 'hC0 + a);
        rd0 = n_rd;
        run_copy(0, 8, 4, 4, lat, b1);
        check("poke_latency", lat, 13);
        repeat (3) @(negedge clk);
        check("poke_reads", n_rd - rd0, 4);
        check("poke_mem8",  int'(mem[8]),  'hC0);
        check("poke_mem11", int'(mem[11]), 'hC3);
        check("poke_mem24", int'(mem[24]), 0);
        check("poke_mem25", int'(mem[25]), 0);
        check("poke_busy_idle", int'(busy), 0);

        // Randomized copies against a byte-at-a-time ascending reference copy.
        for (int it = 0; it < 20; it++) begin
            s = $urandom_range(0, DEPTH - 1);
            d = $urandom_range(0, DEPTH - 1);
            l = (it == 0) ? DEPTH : $urandom_range(0, DEPTH);
            for (int a = 0; a < DEPTH; a++) begin
                byte_v = data_t'($urandom_range(0, 255));
                model[a] = byte_v;
                preload(a, int'(byte_v));
            end
            exp_cs = 0;
            for (int i = 0; i < l; i++) begin
                byte_v = model[(s + i) % DEPTH];
                model[(d + i) % DEPTH] = byte_v;
                exp_cs = exp_cs ^ int'(byte_v);
            end
            run_copy(s, d, l, 0, lat, b1);
            check($sformatf("rand%0d_latency(s=%0d d=%0d l=%0d)", it, s, d, l), lat, 1 + 3 * l);
            @(negedge clk);
            check($sformatf("rand%0d_csum", it), int'(csum), exp_cs);
            bad = 0;
            for (int a = 0; a < DEPTH; a++) if (mem[a] !== model[a]) bad++;
            check($sformatf("rand%0d_mem_bad_bytes", it), bad, 0);
        end

        check("read_write_overlap_cycles", n_ovl, 0);
        check("wrapper_bus_diff_cycles", n_wrap_diff, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
